// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with frame-synchronous double buffering.
// Shares one external hex7seg decoder across all digits via nibble/seg_in.
module seg_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 4
) (
  input  logic        clkin,
  input  logic        greset,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  nibble,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PcntMax = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PcntGuard = PW'(GUARD);

  logic [PW-1:0] pcnt_q;
  logic [1:0]    slot_q;

  logic [15:0] pend_value_q;
  logic [3:0]  pend_dig_en_q, pend_dp_en_q;
  logic        pend_lz_q, pending_q;

  logic [15:0] sh_value_q;
  logic [3:0]  sh_dig_en_q, sh_dp_en_q;
  logic        sh_lz_q;

  logic [3:0] nibble_q, an_q;
  logic       dp_q, blank_q, load_ack_q, frame_done_q;

  logic       boundary, in_guard, blank_d, dp_d;
  logic [3:0] zero_tail, an_d, nibble_d;

  always_comb begin
    boundary = (slot_q == 2'd3) && (pcnt_q == PcntMax);
    in_guard = (pcnt_q < PcntGuard);

    // zero_tail[d]: shadow nibbles d..3 are all zero
    zero_tail[3] = (sh_value_q[15:12] == 4'h0);
    zero_tail[2] = zero_tail[3] && (sh_value_q[11:8] == 4'h0);
    zero_tail[1] = zero_tail[2] && (sh_value_q[7:4] == 4'h0);
    zero_tail[0] = zero_tail[1] && (sh_value_q[3:0] == 4'h0);

    blank_d  = !sh_dig_en_q[slot_q] || (sh_lz_q && (slot_q != 2'd0) && zero_tail[slot_q]);
    nibble_d = sh_value_q[{slot_q, 2'b00} +: 4];
    an_d     = (in_guard || blank_d) ? 4'b1111 : ~(4'b0001 << slot_q);
    dp_d     = !(!in_guard && !blank_d && sh_dp_en_q[slot_q]);
  end

  always_ff @(posedge clkin) begin
    if (!greset) begin
      pcnt_q        <= '0;
      slot_q        <= 2'd0;
      pend_value_q  <= 16'h0;
      pend_dig_en_q <= 4'h0;
      pend_dp_en_q  <= 4'h0;
      pend_lz_q     <= 1'b0;
      pending_q     <= 1'b0;
      sh_value_q    <= 16'h0;
      sh_dig_en_q   <= 4'h0;
      sh_dp_en_q    <= 4'h0;
      sh_lz_q       <= 1'b0;
      nibble_q      <= 4'h0;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
      blank_q       <= 1'b1;
      load_ack_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      if (pcnt_q == PcntMax) begin
        pcnt_q <= '0;
        slot_q <= slot_q + 2'd1;
      end else begin
        pcnt_q <= pcnt_q + 1'b1;
      end

      // A load on the boundary cycle lands in pending and waits a full frame.
      if (load) begin
        pend_value_q  <= value;
        pend_dig_en_q <= dig_en;
        pend_dp_en_q  <= dp_en;
        pend_lz_q     <= lz_blank;
        pending_q     <= 1'b1;
      end else if (boundary && pending_q) begin
        pending_q <= 1'b0;
      end

      if (boundary && pending_q) begin
        sh_value_q  <= pend_value_q;
        sh_dig_en_q <= pend_dig_en_q;
        sh_dp_en_q  <= pend_dp_en_q;
        sh_lz_q     <= pend_lz_q;
      end

      nibble_q     <= nibble_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      load_ack_q   <= boundary && pending_q;
      frame_done_q <= boundary;
    end
  end

  assign nibble     = nibble_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign seg        = blank_q ? 7'h7F : seg_in;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, GUARD=2 (32-cycle frames).
module tb_seg_scan_ctrl;

  logic        clkin = 1'b0;
  logic        greset;
  logic [15:0] value;
  logic [3:0]  dig_en, dp_en;
  logic        lz_blank, load;
  logic        load_ack, dp, frame_done;
  logic [3:0]  nibble, an;
  logic [6:0]  seg_in, seg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [3:0]  dp_en;
    logic        lz;
    logic [15:0] exp_an;   // slot s anodes at bits 4s+:4
    logic [15:0] exp_nib;  // slot s nibble at bits 4s+:4
    logic [3:0]  exp_dp;   // slot s dp level (display phase)
  } vec_t;

  vec_t vecs[6];
  vec_t v_dbl, v_bnd, v_rst, v_first;

  seg_scan_ctrl #(.PRESCALE(8), .GUARD(2)) dut (
    .clkin(clkin), .greset(greset), .value(value), .dig_en(dig_en), .dp_en(dp_en),
    .lz_blank(lz_blank), .load(load), .load_ack(load_ack), .nibble(nibble),
    .seg_in(seg_in), .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );

  // Stand-in decoder: top bit 0 so it never collides with the blank pattern 7F.
  function automatic logic [6:0] segf(input logic [3:0] n);
    return {1'b0, ~n[1:0], n};
  endfunction

  assign seg_in = segf(nibble);

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic apply_load(input vec_t v);
    value    = v.value;
    dig_en   = v.dig_en;
    dp_en    = v.dp_en;
    lz_blank = v.lz;
    load     = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ack();
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load_ack) begin
        got = 1;
        break;
      end
    end
    chk("ack_seen", 16'(got), 16'd1);
    if (got) chk("ack_with_frame_done", 16'(frame_done), 16'd1);
  endtask

  // Called right after the frame_done sample; walks the next full frame.
  task automatic check_frame(input vec_t v);
    logic [3:0] e_an, e_nib;
    logic       e_dp, e_blank;
    int s, p;
    for (int j = 0; j < 32; j++) begin
      tick();
      s       = j / 8;
      p       = j % 8;
      e_an    = v.exp_an[4*s +: 4];
      e_nib   = v.exp_nib[4*s +: 4];
      e_blank = (e_an == 4'b1111);
      e_dp    = v.exp_dp[s];
      chk("nibble", 16'(nibble), 16'(e_nib));
      if (p < 2) begin
        chk("guard_an", 16'(an), 16'hF);
        chk("guard_dp", 16'(dp), 16'd1);
      end else begin
        chk("an", 16'(an), 16'(e_an));
        chk("dp", 16'(dp), 16'(e_dp));
        chk("seg", 16'(seg), 16'(e_blank ? 7'h7F : segf(e_nib)));
      end
      if (j == 31) begin
        chk("frame_done_end", 16'(frame_done), 16'd1);
        chk("no_extra_ack", 16'(load_ack), 16'd0);
      end else begin
        chk("frame_done_mid", 16'(frame_done), 16'd0);
      end
    end
  endtask

  task automatic check_blank_run(input string tag);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk({tag, "_an"}, 16'(an), 16'hF);
      chk({tag, "_seg"}, 16'(seg), 16'h7F);
      chk({tag, "_dp"}, 16'(dp), 16'd1);
      chk({tag, "_ack"}, 16'(load_ack), 16'd0);
      chk({tag, "_frame_done"}, 16'(frame_done), 16'(k == 32));
    end
  endtask

  initial begin
    //          value     dig_en dp_en    lz    exp_an    exp_nib   exp_dp
    vecs[0] = '{16'h12AF, 4'hF, 4'b0010, 1'b0, 16'h7BDE, 16'h12AF, 4'b1101};
    vecs[1] = '{16'h0005, 4'hF, 4'b0000, 1'b1, 16'hFFFE, 16'h0005, 4'b1111};
    vecs[2] = '{16'h0000, 4'hF, 4'b0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1111};
    vecs[3] = '{16'h0500, 4'hF, 4'b0000, 1'b1, 16'hFBDE, 16'h0500, 4'b1111};
    vecs[4] = '{16'h8421, 4'h5, 4'b1111, 1'b0, 16'hFBFE, 16'h8421, 4'b1010};
    vecs[5] = '{16'h0030, 4'hD, 4'b0010, 1'b1, 16'hFFFE, 16'h0030, 4'b1111};
    v_first = '{16'h1111, 4'hF, 4'b0000, 1'b0, 16'h7BDE, 16'h1111, 4'b1111};
    v_dbl   = '{16'h2222, 4'hF, 4'b0000, 1'b0, 16'h7BDE, 16'h2222, 4'b1111};
    v_bnd   = '{16'h3C5A, 4'hF, 4'b1000, 1'b0, 16'h7BDE, 16'h3C5A, 4'b0111};
    v_rst   = '{16'hBEEF, 4'hF, 4'b1111, 1'b0, 16'h7BDE, 16'hBEEF, 4'b0000};

    greset = 1'b0; value = 16'h0; dig_en = 4'h0; dp_en = 4'h0; lz_blank = 1'b0; load = 1'b0;
    repeat (3) tick();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_dp", 16'(dp), 16'd1);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_nibble", 16'(nibble), 16'h0);
    chk("rst_ack", 16'(load_ack), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    greset = 1'b1;
    check_blank_run("idle");

    // Re-align to a frame boundary before the table.
    begin
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (frame_done) begin
          got = 1;
          break;
        end
      end
      chk("align_frame_done", 16'(got), 16'd1);
    end

    for (int i = 0; i < 6; i++) begin
      apply_load(vecs[i]);
      wait_ack();
      check_frame(vecs[i]);
    end

    // Two loads inside one frame: one ack, last data wins.
    apply_load(v_first);
    repeat (5) tick();
    apply_load(v_dbl);
    wait_ack();
    check_frame(v_dbl);

    // Load on the boundary cycle itself is deferred by a whole frame.
    repeat (31) tick();
    value = v_bnd.value; dig_en = v_bnd.dig_en; dp_en = v_bnd.dp_en; lz_blank = v_bnd.lz;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("bnd_frame_done", 16'(frame_done), 16'd1);
    chk("bnd_no_ack", 16'(load_ack), 16'd0);
    begin
      int ack_at = -1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (load_ack) begin
          ack_at = i;
          break;
        end
      end
      chk("bnd_ack_delay", 16'(ack_at), 16'd32);
    end
    check_frame(v_bnd);

    // Reset mid-slot2 with a load pending: data discarded, no ack ever.
    apply_load(v_rst);
    repeat (19) tick();
    greset = 1'b0;
    tick();
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_seg", 16'(seg), 16'h7F);
    chk("mid_rst_dp", 16'(dp), 16'd1);
    chk("mid_rst_nibble", 16'(nibble), 16'h0);
    chk("mid_rst_ack", 16'(load_ack), 16'd0);
    greset = 1'b1;
    check_blank_run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 4-digit seven-segment display. It time-multiplexes one external hex7seg decoder across all four digits: it selects the nibble to decode, drives the active-low anodes and decimal point, and gates the decoded segments. Display data is double-buffered, so new values are applied only at frame boundaries and the display never tears. It replaces the fixed two-digit mux and digit-select pairing in the top level.

Parameters:
PRESCALE, 50000, clock cycles per digit slot (minimum 2; must exceed GUARD)
GUARD, 4, cycles at the start of each slot with all anodes off (anti-ghosting)

Ports:
clkin  in  1  system clock; all state updates on rising edge
greset  in  1  synchronous reset, active-low (0 = reset)
value  in  16  display value; digit d shows value[4d+3:4d]
dig_en  in  4  per-digit enable; 0 forces digit blank
dp_en  in  4  per-digit decimal point request, active-high
lz_blank  in  1  1 = blank leading zero digits
load  in  1  1-cycle request to capture value/dig_en/dp_en/lz_blank
load_ack  out  1  1-cycle pulse when captured data becomes displayed
nibble  out  4  nibble to the external hex7seg decoder
seg_in  in  7  decoded segments returned from hex7seg, active-low
seg  out  7  segments to pins, active-low
an  out  4  anodes, active-low one-hot or all 1
dp  out  1  decimal point, active-low
frame_done  out  1  1-cycle pulse at the end of slot 3

Behaviour:
- Reset (greset=0 at a clock edge):
  - an=4'b1111, dp=1, nibble=0, load_ack=0, frame_done=0.
  - slot=0, prescale count=0, pending=0.
  - Pending and shadow registers cleared: value 0, dig_en 0, dp_en 0, lz_blank 0.
  - The internal blank flag is set, so seg=7'h7F.
  - Reset mid-frame or mid-load discards pending data. No ack is issued.
- Prescaler: pcnt counts 0..PRESCALE-1, then wraps to 0. On the wrap, slot advances 0->1->2->3->0.
- Guard: while pcnt<GUARD, an=4'b1111 and dp=1.
- Display phase: while pcnt>=GUARD, an[slot]=0 and the other anode bits are 1, unless the digit is blank.
- Blank rule for digit d is dig_en_sh[d]==0, OR all of the following hold:
  - lz_blank_sh=1,
  - d>0,
  - shadow nibbles d..3 are all zero.
  Digit 0 is never leading-zero blanked.
- When the digit is blank: an=4'b1111, seg=7'h7F, dp=1.
- dp is 0 only in the display phase of a non-blank digit with dp_en_sh[slot]=1.
- nibble, an, dp and the blank flag are registered and update one cycle after the pcnt/slot change. seg = blank ? 7'h7F : seg_in, combinational from the registered blank flag. hex7seg is combinational on nibble.
- Load handshake:
  - load=1 writes the inputs into the pending registers and sets pending.
  - A second load before the boundary overwrites the pending data. Only one ack follows.
- Frame boundary is the cycle with slot=3 and pcnt=PRESCALE-1. On that cycle:
  - frame_done=1 on the following cycle.
  - If pending was already set before this cycle: shadow <= pending, pending <= 0, and load_ack=1 on the following cycle, aligned with frame_done.
  - A load arriving exactly on the boundary cycle is written to pending. It stays pending until the next boundary.
- Idle holds nothing special; scanning runs continuously out of reset, showing blanks until the first load.
- Widths: pcnt is $clog2(PRESCALE) bits; slot is 2 bits and wraps naturally.

Test Plan (PRESCALE=8, GUARD=2):
- Reset for 3 cycles, then run 40 cycles -> an=4'b1111, seg=7'h7F, dp=1 throughout. frame_done pulses at cycle 32 after reset release. load_ack stays 0.
- load with value=16'h12AF, dig_en=4'hF, dp_en=4'b0010 -> load_ack and frame_done together at the next boundary. Next frame:
  - slot0: an=1110, nibble=F.
  - slot1: an=1101, nibble=A, dp=0.
  - slot2: an=1011, nibble=2.
  - slot3: an=0111, nibble=1.
  - Each slot shows 2 guard cycles of an=1111.
- value=16'h0005, lz_blank=1, dig_en=F -> only digit 0 lights, showing nibble=5. Slots 1-3 show an=1111, seg=7F. value=16'h0000 still lights digit 0 showing 0.
- Two loads (value 16'h1111, then 16'h2222) within one frame -> a single load_ack. The displayed value is 16'h2222.
- load asserted exactly on the boundary cycle -> no ack at that boundary. Ack comes at the following boundary with the new data.
- greset=0 for one cycle mid-slot2 after a pending load -> outputs return to reset values next cycle. No load_ack is ever issued for that load.
